// File: rtl/irq_debounce.sv
// irq_debounce: per-channel 2-flop synchronizer plus N-cycle debounce filter for
// five external interrupt lines, with a small CPU register file (DEB, EN, STATE, EVT).
// Ports: clk/reset (async active-low), raw_in -> irq_in (registered filtered lines),
//        cs/nr_w/adres/data_out register write path, data_in combinational read data.
module irq_debounce (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] raw_in,
  output logic [4:0] irq_in,
  input  logic       cs,
  input  logic       nr_w,
  input  logic [1:0] adres,
  input  logic [7:0] data_out,
  output logic [7:0] data_in
);

  localparam int NCH = 5;

  localparam logic [1:0] ADR_DEB   = 2'b00;
  localparam logic [1:0] ADR_EN    = 2'b01;
  localparam logic [1:0] ADR_STATE = 2'b10;
  localparam logic [1:0] ADR_EVT   = 2'b11;

  logic [4:0] s1_q, s2_q;
  logic [4:0] out_q, out_d;
  logic [4:0] en_q, en_d;
  logic [4:0] evt_q, evt_d;
  logic [7:0] deb_q, deb_d;
  logic [7:0] cnt_q [NCH];
  logic [7:0] cnt_d [NCH];

  logic       wr_en, deb_wr, en_wr, evt_wr;
  logic [7:0] n_last;
  logic [4:0] evt_set;

  assign wr_en  = cs & nr_w;
  assign deb_wr = wr_en && (adres == ADR_DEB);
  assign en_wr  = wr_en && (adres == ADR_EN);
  assign evt_wr = wr_en && (adres == ADR_EVT);

  // A length of 0 behaves as 1; the counter compares against N-1.
  assign n_last = (deb_q == 8'd0) ? 8'd0 : (deb_q - 8'd1);

  always_comb begin
    out_d   = out_q;
    evt_set = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!en_q[i]) begin
        // Disabled channel is held low silently; no event is logged for this clear.
        out_d[i] = 1'b0;
        cnt_d[i] = 8'd0;
      end else if (deb_wr) begin
        // A new length restarts every debounce in progress; outputs hold.
        cnt_d[i] = 8'd0;
      end else if (s2_q[i] != out_q[i]) begin
        if (cnt_q[i] == n_last) begin
          out_d[i]   = s2_q[i];
          cnt_d[i]   = 8'd0;
          evt_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = 8'd0;
      end
    end
  end

  assign deb_d = deb_wr ? data_out : deb_q;
  assign en_d  = en_wr ? data_out[4:0] : en_q;
  // Write-1-to-clear, with a same-edge set taking priority.
  assign evt_d = (evt_q & ~(evt_wr ? data_out[4:0] : 5'b0)) | evt_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
      evt_q <= '0;
      en_q  <= 5'b11111;
      deb_q <= 8'h04;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= 8'd0;
    end else begin
      s1_q  <= raw_in;
      s2_q  <= s1_q;
      out_q <= out_d;
      evt_q <= evt_d;
      en_q  <= en_d;
      deb_q <= deb_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign irq_in = out_q;

  always_comb begin
    data_in = 8'h00;
    if (cs && !nr_w) begin
      case (adres)
        ADR_DEB:   data_in = deb_q;
        ADR_EN:    data_in = {3'b000, en_q};
        ADR_STATE: data_in = {3'b000, out_q};
        ADR_EVT:   data_in = {3'b000, evt_q};
        default:   data_in = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_debounce.sv
module tb_irq_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raw_in;
  logic [4:0] irq_in;
  logic       cs;
  logic       nr_w;
  logic [1:0] adres;
  logic [7:0] data_out;
  logic [7:0] data_in;

  int total = 0;
  int bad   = 0;

  irq_debounce dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (raw_in),
    .irq_in   (irq_in),
    .cs       (cs),
    .nr_w     (nr_w),
    .adres    (adres),
    .data_out (data_out),
    .data_in  (data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; nr_w = 1'b1; adres = a; data_out = d;
    tick();
    cs = 1'b0; nr_w = 1'b0; data_out = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    cs = 1'b1; nr_w = 1'b0; adres = a;
    #1;
    v = data_in;
    cs = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    reset = 1'b0; raw_in = '0; cs = 1'b0; nr_w = 1'b0; adres = '0; data_out = '0;
    #1;
    chk("irq_in_in_reset", {3'b0, irq_in}, 8'h00);
    tick(); tick();
    reset = 1'b1;

    // Reset values
    rd(2'b00, v); chk("rst_deb", v, 8'h04);
    rd(2'b01, v); chk("rst_en", v, 8'h1F);
    rd(2'b10, v); chk("rst_state", v, 8'h00);
    rd(2'b11, v); chk("rst_evt", v, 8'h00);
    chk("data_in_idle", data_in, 8'h00);

    // N=3 rise on ch0: sampled at edge k, visible at k+4
    wr(2'b00, 8'd3);
    raw_in = 5'h01;
    tick(); tick(); tick(); tick();            // edges k..k+3
    chk("n3_before", {3'b0, irq_in}, 8'h00);
    tick();                                     // edge k+4
    chk("n3_at", {3'b0, irq_in}, 8'h01);
    rd(2'b11, v); chk("n3_evt", v, 8'h01);
    wr(2'b11, 8'h1F);
    rd(2'b11, v); chk("evt_w1c", v, 8'h00);

    // N=4, 3-cycle glitch on ch2 must be rejected
    wr(2'b00, 8'd4);
    rd(2'b00, v); chk("deb_rb", v, 8'h04);
    raw_in = 5'h05;
    tick(); tick(); tick();
    raw_in = 5'h01;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_irq", {3'b0, irq_in}, 8'h01);
    end
    rd(2'b11, v); chk("glitch_evt", v, 8'h00);

    // Bring ch1 high, then disable/re-enable it
    raw_in = 5'h03;
    repeat (6) tick();
    chk("ch1_high", {3'b0, irq_in}, 8'h03);
    rd(2'b10, v); chk("state_rd", v, 8'h03);
    wr(2'b11, 8'h1F);
    wr(2'b10, 8'h00);                           // STATE is read-only
    rd(2'b10, v); chk("state_ro", v, 8'h03);
    wr(2'b01, 8'h1D);
    tick();
    chk("dis_irq", {3'b0, irq_in}, 8'h01);
    rd(2'b11, v); chk("dis_no_evt", v, 8'h00);
    rd(2'b01, v); chk("en_rb", v, 8'h1D);
    wr(2'b01, 8'h1F);                           // write edge e
    tick(); tick(); tick();                     // e+1..e+3
    chk("reen_before", {3'b0, irq_in}, 8'h01);
    tick();                                     // e+4 = N+1 edges incl. write
    chk("reen_at", {3'b0, irq_in}, 8'h03);
    rd(2'b11, v); chk("reen_evt", v, 8'h02);
    wr(2'b11, 8'h1F);

    // Set-wins over W1C on ch3
    raw_in = 5'h0B;
    repeat (6) tick();
    chk("ch3_high", {3'b0, irq_in}, 8'h0B);
    rd(2'b11, v); chk("ch3_evt", v, 8'h08);
    raw_in = 5'h03;
    tick(); tick(); tick(); tick(); tick();     // edges k..k+4
    chk("ch3_pre_fall", {3'b0, irq_in}, 8'h0B);
    wr(2'b11, 8'h08);                           // edge k+5: fall and W1C together
    chk("ch3_fell", {3'b0, irq_in}, 8'h03);
    rd(2'b11, v); chk("set_wins", v, 8'h08);
    wr(2'b11, 8'h08);
    rd(2'b11, v); chk("later_w1c", v, 8'h00);

    // N=0 behaves as N=1: out two edges after sampling
    wr(2'b00, 8'd0);
    raw_in = 5'h00;
    tick();                                     // k
    chk("n0_k", {3'b0, irq_in}, 8'h03);
    tick();                                     // k+1
    chk("n0_k1", {3'b0, irq_in}, 8'h03);
    tick();                                     // k+2
    chk("n0_k2", {3'b0, irq_in}, 8'h00);
    wr(2'b11, 8'h1F);

    // Reset mid-count with all lines high
    wr(2'b00, 8'd4);
    raw_in = 5'h1F;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_async_irq", {3'b0, irq_in}, 8'h00);
    rd(2'b00, v); chk("rst_async_deb", v, 8'h04);
    rd(2'b11, v); chk("rst_async_evt", v, 8'h00);
    #1;
    reset = 1'b1;
    tick(); tick(); tick(); tick();             // k..k+3
    chk("rst_rel_before", {3'b0, irq_in}, 8'h00);
    tick();                                     // k+4
    chk("rst_rel_k4", {3'b0, irq_in}, 8'h00);
    tick();                                     // k+5
    chk("rst_rel_at", {3'b0, irq_in}, 8'h1F);
    rd(2'b11, v); chk("rst_rel_evt", v, 8'h1F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
